player_input_encoder: RTL

Per-player front end that turns raw button levels (four direction keys plus a bomb key) into the `direction` / `bomb` / `in_valid` command stream consumed by the game controller. It synchronizes and debounces each key, resolves simultaneous presses, and emits one-cycle `in_valid` events with typematic auto-repeat for held directions. One instance is placed per player, between the board I/O (keys/GPIO) and the controller's player inputs.

---
 rtl/player_input_encoder.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/player_input_encoder.sv
// Per-player key front end: 2-FF sync, per-key debounce, UP>DOWN>LEFT>RIGHT resolution,
// typematic auto-repeat FSM and one-cycle in_valid_o strobes with bomb merging.
// Ports: clk/rst (async active-high), i_enable, five raw keys in; direction_o, bomb_o, in_valid_o out.
module player_input_encoder #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int FIRST_DELAY     = 12500000,
  parameter int REPEAT_CYCLES   = 5000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_enable,
  input  logic       i_key_up,
  input  logic       i_key_down,
  input  logic       i_key_left,
  input  logic       i_key_right,
  input  logic       i_key_bomb,
  output logic [2:0] direction_o,
  output logic       bomb_o,
  output logic       in_valid_o
);

  localparam int MAX_A = (DEBOUNCE_CYCLES > FIRST_DELAY) ? DEBOUNCE_CYCLES : FIRST_DELAY;
  localparam int MAX_P = (MAX_A > REPEAT_CYCLES) ? MAX_A : REPEAT_CYCLES;
  localparam int TW    = $clog2(MAX_P);
  localparam int DW    = $clog2(DEBOUNCE_CYCLES + 1);

  // Timer is loaded with N-1 and an expiry is seen when it reads 0, so the
  // next pulse lands exactly N cycles after the one that loaded it.
  localparam logic [TW-1:0] FIRST_LOAD  = TW'(FIRST_DELAY - 1);
  localparam logic [TW-1:0] REPEAT_LOAD = TW'(REPEAT_CYCLES - 1);
  localparam logic [DW-1:0] DB_LAST     = DW'(DEBOUNCE_CYCLES - 1);

  localparam logic [2:0] DIR_UP    = 3'd0;
  localparam logic [2:0] DIR_DOWN  = 3'd1;
  localparam logic [2:0] DIR_LEFT  = 3'd2;
  localparam logic [2:0] DIR_RIGHT = 3'd3;
  localparam logic [2:0] DIR_STOP  = 3'd4;

  typedef enum logic [1:0] {ST_IDLE, ST_FIRST, ST_REPEAT} state_t;

  // Key vector order: up, down, left, right, bomb (bit 0..4).
  logic [4:0]    raw;
  logic [4:0]    sync1_q, sync1_d, sync2_q, sync2_d, deb_q, deb_d;
  logic [DW-1:0] cnt_q [5];
  logic [DW-1:0] cnt_d [5];
  logic          bomb_prev_q, bomb_prev_d;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    cur_dir_q, cur_dir_d;
  logic          pend_q, pend_d, pend_bomb_q, pend_bomb_d;
  logic [2:0]    dir_out_q, dir_out_d;
  logic          bomb_out_q, bomb_out_d, valid_q, valid_d;

  logic          act_vld;
  logic [2:0]    act_dir;
  logic          bomb_rise;
  logic          dir_evt;
  logic          evt;
  logic          bomb_now;

  assign raw = {i_key_bomb, i_key_right, i_key_left, i_key_down, i_key_up};

  // ---------------- synchronizers and debouncers ----------------
  always_comb begin
    sync1_d     = raw;
    sync2_d     = sync1_q;
    deb_d       = deb_q;
    bomb_prev_d = deb_q[4];
    for (int k = 0; k < 5; k++) begin
      cnt_d[k] = '0;
      if (sync2_q[k] != deb_q[k]) begin
        if (cnt_q[k] == DB_LAST) begin
          deb_d[k] = sync2_q[k];
        end else begin
          cnt_d[k] = cnt_q[k] + DW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      deb_q       <= '0;
      bomb_prev_q <= 1'b0;
      for (int k = 0; k < 5; k++) cnt_q[k] <= '0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      deb_q       <= deb_d;
      bomb_prev_q <= bomb_prev_d;
      for (int k = 0; k < 5; k++) cnt_q[k] <= cnt_d[k];
    end
  end

  // ---------------- direction priority ----------------
  always_comb begin
    act_vld = 1'b1;
    act_dir = DIR_STOP;
    if (deb_q[0])      act_dir = DIR_UP;
    else if (deb_q[1]) act_dir = DIR_DOWN;
    else if (deb_q[2]) act_dir = DIR_LEFT;
    else if (deb_q[3]) act_dir = DIR_RIGHT;
    else               act_vld = 1'b0;
  end

  // bomb_prev tracks even while disabled, so a bomb still held at re-enable is no edge.
  assign bomb_rise = deb_q[4] & ~bomb_prev_q;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      timer_q     <= '0;
      cur_dir_q   <= DIR_STOP;
      pend_q      <= 1'b0;
      pend_bomb_q <= 1'b0;
      dir_out_q   <= DIR_STOP;
      bomb_out_q  <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      cur_dir_q   <= cur_dir_d;
      pend_q      <= pend_d;
      pend_bomb_q <= pend_bomb_d;
      dir_out_q   <= dir_out_d;
      bomb_out_q  <= bomb_out_d;
      valid_q     <= valid_d;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    cur_dir_d = cur_dir_q;
    dir_evt   = 1'b0;
    if (!i_enable) begin
      state_d   = ST_IDLE;
      timer_d   = '0;
      cur_dir_d = DIR_STOP;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (act_vld) begin
            state_d   = ST_FIRST;
            timer_d   = FIRST_LOAD;
            cur_dir_d = act_dir;
            dir_evt   = 1'b1;
          end
        end
        ST_FIRST, ST_REPEAT: begin
          if (!act_vld) begin
            state_d   = ST_IDLE;
            timer_d   = '0;
            cur_dir_d = DIR_STOP;
          end else if (act_dir != cur_dir_q) begin
            state_d   = ST_FIRST;
            timer_d   = FIRST_LOAD;
            cur_dir_d = act_dir;
            dir_evt   = 1'b1;
          end else if (timer_q == '0) begin
            state_d   = ST_REPEAT;
            timer_d   = REPEAT_LOAD;
            dir_evt   = 1'b1;
          end else begin
            timer_d   = timer_q - TW'(1);
          end
        end
        default: begin
          state_d   = ST_IDLE;
          timer_d   = '0;
          cur_dir_d = DIR_STOP;
        end
      endcase
    end
  end

  // ---------------- FSM: outputs ----------------
  // Every source firing this cycle merges into one event; an event landing
  // right after a strobe is parked for one cycle to keep strobes apart.
  always_comb begin
    evt         = dir_evt | pend_q | bomb_rise;
    bomb_now    = bomb_rise | pend_bomb_q;
    valid_d     = 1'b0;
    pend_d      = 1'b0;
    pend_bomb_d = 1'b0;
    dir_out_d   = dir_out_q;
    bomb_out_d  = bomb_out_q;
    if (!i_enable) begin
      dir_out_d  = DIR_STOP;
      bomb_out_d = 1'b0;
    end else if (evt) begin
      if (valid_q) begin
        pend_d      = 1'b1;
        pend_bomb_d = bomb_now;
      end else begin
        valid_d    = 1'b1;
        dir_out_d  = act_dir;
        bomb_out_d = bomb_now;
      end
    end
  end

  assign direction_o = dir_out_q;
  assign bomb_o      = bomb_out_q;
  assign in_valid_o  = valid_q;

endmodule
